// File: rtl/hamming_codec_arbiter.sv
// Two-requester arbiter sharing one Hamming(7,4) encode/correct datapath with a registered response.
// Optional saturating corrected-error counter enabled by macro HAMMING_ARB_ERRCNT_EN.
module hamming_codec_arbiter #(
   parameter int unsigned ERR_CNT_W = 8,
   parameter int unsigned RR_EN_P   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic                 a_op,
   input  logic [6:0]           a_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic                 b_op,
   input  logic [6:0]           b_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [6:0]           rsp_data,
   output logic [2:0]           rsp_syn,
   output logic                 rsp_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StResp = 1'b1;

   logic [0:0] state_q;
   logic       last_grant_q;  // 1 = B was granted last
   logic       grant_b;
   logic       can_accept;
   logic       accept;
   logic       sel_op;
   logic [6:0] sel_data;
   logic [6:0] enc_cw;
   logic [2:0] syn;
   logic [6:0] flip;
   logic [6:0] corr;
   logic [6:0] res_data;
   logic [2:0] res_syn;

   always_comb begin
      grant_b    = b_valid & (~a_valid | ((RR_EN_P != 0) & ~last_grant_q));
      can_accept = (state_q == StIdle) | rsp_ready;
      a_ready    = rst_n & can_accept & a_valid & ~grant_b;
      b_ready    = rst_n & can_accept & grant_b;
      accept     = a_ready | b_ready;
      sel_op     = grant_b ? b_op : a_op;
      sel_data   = grant_b ? b_data : a_data;
   end

   always_comb begin
      enc_cw    = 7'd0;
      enc_cw[6] = sel_data[3];
      enc_cw[5] = sel_data[2];
      enc_cw[4] = sel_data[1];
      enc_cw[2] = sel_data[0];
      enc_cw[0] = enc_cw[6] ^ enc_cw[4] ^ enc_cw[2];
      enc_cw[1] = enc_cw[6] ^ enc_cw[5] ^ enc_cw[2];
      enc_cw[3] = enc_cw[6] ^ enc_cw[5] ^ enc_cw[4];

      syn[0] = sel_data[0] ^ sel_data[6] ^ sel_data[4] ^ sel_data[2];
      syn[1] = sel_data[1] ^ sel_data[6] ^ sel_data[5] ^ sel_data[2];
      syn[2] = sel_data[3] ^ sel_data[6] ^ sel_data[5] ^ sel_data[4];
      // Syndrome k points at cw[k-1]; parity-bit hits leave the data bits untouched.
      flip   = (syn == 3'd0) ? 7'd0 : (7'd1 << (syn - 3'd1));
      corr   = sel_data ^ flip;

      if (sel_op) begin
         res_data = {3'b000, corr[6], corr[5], corr[4], corr[2]};
         res_syn  = syn;
      end else begin
         res_data = enc_cw;
         res_syn  = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         rsp_id       <= 1'b0;
         rsp_data     <= 7'd0;
         rsp_syn      <= 3'd0;
         rsp_err      <= 1'b0;
      end else if (accept) begin
         state_q      <= StResp;
         last_grant_q <= grant_b;
         rsp_id       <= grant_b;
         rsp_data     <= res_data;
         rsp_syn      <= res_syn;
         rsp_err      <= (res_syn != 3'd0);
      end else if (rsp_ready) begin
         state_q      <= StIdle;
      end
   end

   assign rsp_valid = (state_q == StResp);

`ifdef HAMMING_ARB_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_q <= '0;
      end else if (accept && sel_op && (syn != 3'd0) && !(&err_count_q)) begin
         err_count_q <= err_count_q + ERR_CNT_W'(1);
      end
   end

   assign err_count = err_count_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// Scoreboard bench for hamming_codec_arbiter: a negedge monitor models arbitration, pushes
// expected responses on each handshake and compares them while the response is presented.
module tb_hamming_codec_arbiter;

   localparam int unsigned CntW   = 2;
   localparam int unsigned RrEn   = 1;
   localparam int unsigned CntMax = (1 << CntW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            a_valid = 1'b0, a_op = 1'b0;
   logic [6:0]      a_data = 7'd0;
   logic            b_valid = 1'b0, b_op = 1'b0;
   logic [6:0]      b_data = 7'd0;
   logic            rsp_ready = 1'b1;
   logic            a_ready, b_ready, rsp_valid, rsp_id, rsp_err;
   logic [6:0]      rsp_data;
   logic [2:0]      rsp_syn;
   logic [CntW-1:0] err_count;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [11:0] sb_q[$];  // {id, data[6:0], syn[2:0], err}
   logic        tb_last = 1'b1;
   int unsigned tb_cnt  = 0;

   hamming_codec_arbiter #(.ERR_CNT_W(CntW), .RR_EN_P(RrEn)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_data(b_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_syn(rsp_syn), .rsp_err(rsp_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Model built from bit positions: syndrome is the XOR of 1-based positions of set bits.
   function automatic logic [11:0] model(input logic id, input logic op, input logic [6:0] d);
      logic [6:0] cw;
      logic [2:0] s;
      cw = 7'd0;
      s  = 3'd0;
      if (!op) begin
         cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
         for (int k = 1; k <= 7; k++) if (cw[k-1]) s ^= 3'(k);
         cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
         return {id, cw, 3'd0, 1'b0};
      end
      for (int k = 1; k <= 7; k++) if (d[k-1]) s ^= 3'(k);
      cw = d;
      if (s != 3'd0) cw[s-1] = ~cw[s-1];
      return {id, 3'b000, cw[6], cw[5], cw[4], cw[2], s, (s != 3'd0)};
   endfunction

   task automatic push(input logic id, input logic op, input logic [6:0] d);
      logic [11:0] e;
      e = model(id, op, d);
      sb_q.push_back(e);
      tb_last = id;
`ifdef HAMMING_ARB_ERRCNT_EN
      if (op && e[3:1] != 3'd0 && tb_cnt < CntMax) tb_cnt++;
`endif
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_v, can, ga, gb;
         logic [11:0] f;
         exp_v = (sb_q.size() != 0);
         can   = !exp_v || rsp_ready;
         ga    = a_valid && (!b_valid || (RrEn != 0 && tb_last));
         gb    = b_valid && !ga;
         check("a_ready", 32'(a_ready), 32'(can && ga));
         check("b_ready", 32'(b_ready), 32'(can && gb));
         check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
         check("err_count", 32'(err_count), tb_cnt);
         if (exp_v) begin
            f = sb_q[0];
            check("rsp", {20'd0, rsp_id, rsp_data, rsp_syn, rsp_err}, {20'd0, f});
            if (rsp_ready) void'(sb_q.pop_front());
         end
         if (a_valid && a_ready) push(1'b0, a_op, a_data);
         else if (b_valid && b_ready) push(1'b1, b_op, b_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic av, input logic aop, input logic [6:0] ad,
                          input logic bv, input logic bop, input logic [6:0] bd);
      a_valid = av; a_op = aop; a_data = ad;
      b_valid = bv; b_op = bop; b_data = bd;
   endtask

   initial begin
      step();
      step();
      rst_n = 1'b1;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_data", 32'(rsp_data), 32'd0);
      check("rst_syn", 32'(rsp_syn), 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_cnt", 32'(err_count), 32'd0);

      // Directed vectors
      set_req(1, 0, 7'h0B, 0, 0, 7'h00);
      step();
      set_req(0, 0, 7'h00, 1, 1, 7'h75);
      check("enc_valid", 32'(rsp_valid), 32'd1);
      check("enc_data", 32'(rsp_data), 32'h55);
      check("enc_err", 32'(rsp_err), 32'd0);
      step();
      set_req(1, 1, 7'h54, 0, 0, 7'h00);
      check("dec75_id", 32'(rsp_id), 32'd1);
      check("dec75_data", 32'(rsp_data), 32'h0B);
      check("dec75_syn", 32'(rsp_syn), 32'd6);
      check("dec75_err", 32'(rsp_err), 32'd1);
      step();
      set_req(1, 1, 7'h55, 0, 0, 7'h00);
      check("dec54_data", 32'(rsp_data), 32'h0B);
      check("dec54_syn", 32'(rsp_syn), 32'd1);
      step();
      set_req(0, 0, 7'h00, 0, 0, 7'h00);
      check("dec55_err", 32'(rsp_err), 32'd0);
      step();

      // Both requesters busy every cycle
      for (int i = 0; i < 10; i++) begin
         set_req(1, 1'($urandom), 7'($urandom), 1, 1'($urandom), 7'($urandom));
         step();
      end

      // Stall with A pending, then release
      set_req(1, 0, 7'h03, 0, 0, 7'h00);
      step();
      rsp_ready = 1'b0;
      a_data = 7'h0C;
      for (int i = 0; i < 5; i++) step();
      rsp_ready = 1'b1;
      step();
      set_req(0, 0, 7'h00, 0, 0, 7'h00);
      step();

      // Corrupted decodes to reach counter saturation
      for (int i = 0; i < 5; i++) begin
         set_req(1, 1, 7'h55 ^ 7'(1 << (i % 7)), 0, 0, 7'h00);
         step();
      end
      set_req(0, 0, 7'h00, 0, 0, 7'h00);
      step();
      check("sat_cnt", 32'(err_count), tb_cnt);

      // Random traffic with random back-pressure
      for (int i = 0; i < 80; i++) begin
         set_req(1'($urandom), 1'($urandom), 7'($urandom),
                 1'($urandom), 1'($urandom), 7'($urandom));
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Asynchronous reset with a response held
      rsp_ready = 1'b0;
      set_req(1, 1, 7'h75, 1, 0, 7'h05);
      step();
      step();
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(rsp_valid), 32'd0);
      check("arst_cnt", 32'(err_count), 32'd0);
      check("arst_a_ready", 32'(a_ready), 32'd0);
      check("arst_b_ready", 32'(b_ready), 32'd0);
      sb_q.delete();
      tb_last = 1'b1;
      tb_cnt  = 0;
      set_req(0, 0, 7'h00, 0, 0, 7'h00);
      rsp_ready = 1'b1;
      step();
      rst_n = 1'b1;
      set_req(1, 0, 7'h0F, 1, 0, 7'h01);
      step();
      step();
      set_req(0, 0, 7'h00, 0, 0, 7'h00);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
